// File: rtl/core_clock_enables.sv
// Clean core reset from PLL lock, plus the 32.768 kHz real-time enable and a
// speed-scaled, pausable CPU enable, all derived from the single 13.1072 MHz clock.
module core_clock_enables #(
    parameter int DIVIDER   = 400,
    parameter int LOCK_HOLD = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic [1:0] speed,
    input  logic       pause,
    output logic       core_reset_n,
    output logic       ce_32k,
    output logic       ce_cpu
);

    localparam int CNT_W  = $clog2(DIVIDER);
    localparam int HOLD_W = $clog2(LOCK_HOLD + 1);
    localparam logic [CNT_W-1:0]  RT_LAST  = CNT_W'(DIVIDER - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LOCK_HOLD);

    logic              sync_p0;
    logic              lock_s;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_next;
    logic              run_next;
    logic              div_clear;
    logic [CNT_W-1:0]  rt_cnt;
    logic [CNT_W-1:0]  cpu_cnt;
    logic [CNT_W-1:0]  cpu_last;
    logic [1:0]        spd_l;
    logic              rt_wrap;
    logic              cpu_wrap;

    always_comb begin
        hold_next = '0;
        if (lock_s) begin
            hold_next = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HOLD_W'(1);
        end
        // Core leaves reset on the same edge the count saturates and drops on the
        // very edge after lock_s falls.
        run_next  = (hold_next == HOLD_MAX);
        // Dividers sit at zero while the core is (or is about to be) in reset.
        div_clear = !run_next || !core_reset_n;
        cpu_last  = CNT_W'(DIVIDER >> spd_l) - CNT_W'(1);
        rt_wrap   = core_reset_n && (rt_cnt == RT_LAST);
        cpu_wrap  = core_reset_n && !pause && (cpu_cnt == cpu_last);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_p0      <= 1'b0;
            lock_s       <= 1'b0;
            hold_cnt     <= '0;
            core_reset_n <= 1'b0;
            rt_cnt       <= '0;
            cpu_cnt      <= '0;
            spd_l        <= speed;
        end else begin
            sync_p0      <= pll_locked;
            lock_s       <= sync_p0;
            hold_cnt     <= hold_next;
            core_reset_n <= run_next;
            if (div_clear) begin
                rt_cnt  <= '0;
                cpu_cnt <= '0;
                spd_l   <= speed;
            end else begin
                rt_cnt <= rt_wrap ? '0 : rt_cnt + CNT_W'(1);
                // Speed is only picked up at a wrap so no period is ever cut short.
                if (!pause) begin
                    if (cpu_wrap) begin
                        cpu_cnt <= '0;
                        spd_l   <= speed;
                    end else begin
                        cpu_cnt <= cpu_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign ce_32k = rt_wrap;
    assign ce_cpu = cpu_wrap;

endmodule

// File: tb/tb_core_clock_enables.sv
// Bench for core_clock_enables: vector table, hand-written corner sequences and
// a randomized run against an event-time reference model.
module tb_core_clock_enables;

    localparam int D  = 400;
    localparam int LH = 1024;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_locked = 1'b1;
    logic [1:0] speed = 2'd0;
    logic       pause = 1'b0;
    logic       core_reset_n;
    logic       ce_32k;
    logic       ce_cpu;

    core_clock_enables #(.DIVIDER(D), .LOCK_HOLD(LH)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .pll_locked(pll_locked),
        .speed(speed),
        .pause(pause),
        .core_reset_n(core_reset_n),
        .ce_32k(ce_32k),
        .ce_cpu(ce_cpu)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: lock_s is pll_locked delayed two cycles; the core runs once
    // lock_s has been high for LOCK_HOLD consecutive earlier cycles; ce_32k fires
    // every D-th cycle of a run; ce_cpu fires at a scheduled cycle that each
    // paused cycle pushes back by one.
    int cyc = 0;
    bit valid = 0;
    bit m_d1 = 0;
    bit m_d2 = 0;
    int streak = 0;
    int age = 0;
    int due = 0;

    bit s_ce32;
    bit s_cpu;
    int s_cyc;

    typedef struct {
        bit         rst_n;
        bit         pll;
        logic [1:0] spd;
        bit         pau;
        int         len;
        bit         e_core;
        bit         e_32k;
        bit         e_cpu;
    } vec_t;

    vec_t tbl[$];

    task automatic check3(input string name, input logic a_core, input logic a_32k,
                          input logic a_cpu, input bit e_core, input bit e_32k, input bit e_cpu);
        checks++;
        if ({a_core, a_32k, a_cpu} !== {e_core, e_32k, e_cpu}) begin
            errors++;
            $display("FAIL %s cycle=%0d got core_reset_n,ce_32k,ce_cpu=%b%b%b expected %b%b%b",
                     name, cyc, a_core, a_32k, a_cpu, e_core, e_32k, e_cpu);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Called at a falling edge with inputs set; checks and steps one clock.
    task automatic tick();
        bit ec, e32, ecpu, nc;
        int ns;
        #1;
        ec   = (streak >= LH);
        e32  = ec && ((age % D) == D - 1);
        ecpu = ec && !pause && (cyc == due);
        if (valid) check3("model", core_reset_n, ce_32k, ce_cpu, ec, e32, ecpu);
        s_ce32 = ce_32k;
        s_cpu  = ce_cpu;
        s_cyc  = cyc;
        if (!reset_n) begin
            m_d1  = 0;
            m_d2  = 0;
            ns    = 0;
            valid = 1;
        end else begin
            ns   = m_d2 ? ((streak < LH) ? streak + 1 : streak) : 0;
            m_d2 = m_d1;
            m_d1 = pll_locked;
        end
        nc = (ns >= LH);
        if (ec && nc) age++;
        else age = 0;
        if (!(ec && nc)) due = cyc + (D >> speed);
        else if (pause) due++;
        else if (cyc == due) due = cyc + (D >> speed);
        streak = ns;
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_cpu(output int at);
        int n;
        n  = 0;
        at = -1;
        while (at < 0 && n < 1000) begin
            tick();
            n++;
            if (s_cpu) at = s_cyc;
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_cpu got no ce_cpu within 1000 cycles required one");
        end
    endtask

    initial begin
        int p1, p2, p3, q, c32, cc;
        int drop_left;

        // rst_n pll spd pau len | core 32k cpu      (R = 1026 = first run cycle)
        tbl.push_back('{0, 1, 2'd0, 0, 4,    0, 0, 0});  // held in reset
        tbl.push_back('{1, 1, 2'd0, 0, 1025, 0, 0, 0});  // cycle 1025
        tbl.push_back('{1, 1, 2'd0, 0, 1,    1, 0, 0});  // cycle 1026 release
        tbl.push_back('{1, 1, 2'd0, 0, 398,  1, 0, 0});  // R+398
        tbl.push_back('{1, 1, 2'd0, 0, 1,    1, 1, 1});  // R+399 first pulses
        tbl.push_back('{1, 1, 2'd0, 0, 1,    1, 0, 0});  // R+400
        tbl.push_back('{1, 1, 2'd3, 0, 398,  1, 0, 0});  // speed 3 waits for wrap
        tbl.push_back('{1, 1, 2'd3, 0, 1,    1, 1, 1});  // R+799
        tbl.push_back('{1, 1, 2'd3, 0, 50,   1, 0, 1});  // R+849 period 50
        tbl.push_back('{1, 1, 2'd3, 0, 50,   1, 0, 1});  // R+899
        tbl.push_back('{1, 1, 2'd3, 1, 40,   1, 0, 0});  // pause lands on wrap
        tbl.push_back('{1, 1, 2'd3, 0, 0,    1, 0, 1});  // deferred wrap R+939
        tbl.push_back('{1, 1, 2'd3, 0, 50,   1, 0, 1});  // R+989
        tbl.push_back('{1, 0, 2'd3, 0, 1,    1, 0, 0});  // one-cycle lock drop
        tbl.push_back('{1, 1, 2'd3, 0, 1,    1, 0, 0});  // R+991
        tbl.push_back('{1, 1, 2'd3, 0, 1,    0, 0, 0});  // R+992 core reset
        tbl.push_back('{1, 1, 2'd3, 0, 1023, 0, 0, 0});  // R+2015
        tbl.push_back('{1, 1, 2'd3, 0, 1,    1, 0, 0});  // R+2016 = return+1026
        tbl.push_back('{1, 1, 2'd3, 0, 399,  1, 1, 1});  // R+2415
        tbl.push_back('{0, 1, 2'd3, 0, 1,    0, 0, 0});  // reset mid-run
        tbl.push_back('{1, 1, 2'd3, 0, 1025, 0, 0, 0});
        tbl.push_back('{1, 1, 2'd3, 0, 1,    1, 0, 0});

        @(negedge clk);
        foreach (tbl[i]) begin
            reset_n    = tbl[i].rst_n;
            pll_locked = tbl[i].pll;
            speed      = tbl[i].spd;
            pause      = tbl[i].pau;
            repeat (tbl[i].len) tick();
            #1;
            check3($sformatf("row%0d", i), core_reset_n, ce_32k, ce_cpu,
                   tbl[i].e_core, tbl[i].e_32k, tbl[i].e_cpu);
        end

        // Pulse counts over a 4000-cycle window at speed 3.
        repeat (400) tick();
        c32 = 0;
        cc  = 0;
        repeat (4000) begin
            tick();
            c32 += int'(s_ce32);
            cc  += int'(s_cpu);
        end
        check_int("ce_32k_count_4000", c32, 10);
        check_int("ce_cpu_count_4000_spd3", cc, 80);

        // Speed 3 -> 1 mid-period.
        wait_cpu(p1);
        repeat (20) tick();
        speed = 2'd1;
        wait_cpu(p2);
        wait_cpu(p3);
        check_int("speed_change_cur_period", p2 - p1, 50);
        check_int("speed_change_next_period", p3 - p2, 200);

        // Pause from 10 cycles before a ce_cpu, for 1000 cycles.
        wait_cpu(p1);
        repeat (189) tick();
        pause = 1'b1;
        c32 = 0;
        cc  = 0;
        repeat (1000) begin
            tick();
            c32 += int'(s_ce32);
            cc  += int'(s_cpu);
        end
        check_int("ce_cpu_during_pause", cc, 0);
        check_int("ce_32k_during_pause_in_2_3", int'(c32 == 2 || c32 == 3), 1);
        pause = 1'b0;
        q = cyc;
        wait_cpu(p2);
        check_int("resume_after_pause", p2 - q, 10);

        // Randomized run against the model.
        drop_left = 0;
        repeat (20000) begin
            reset_n = ($urandom_range(0, 4999) != 0);
            if (drop_left > 0) begin
                pll_locked = 1'b0;
                drop_left--;
            end else begin
                pll_locked = 1'b1;
                if ($urandom_range(0, 2999) == 0) drop_left = $urandom_range(1, 4);
            end
            if ($urandom_range(0, 149) == 0) speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 79) == 0) pause = ~pause;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
